// File: rtl/clock_tick_ctrl.sv
// clock_tick_ctrl: mode sequencer and single-cycle enable generator for the
// digital clock. Produces the 1 Hz seconds tick, hour/minute increment
// pulses, the seconds-clear pulse and blink-blanking strobes.
// Optional build macro: AUTO_REPEAT_EN adds hold-to-repeat on btn_inc.
module clock_tick_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int BLINK_HZ  = 2,
  parameter int HOLD_CYC  = 25000000,
  parameter int REPEAT_HZ = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blank_hr,
  output logic       blank_min
);

  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW = $clog2(CLK_HZ - 1) + 1;
  localparam int BW = $clog2(BLINK_HALF - 1) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // Reject configurations that would make a counter terminal value negative.
  if (CLK_HZ < 2 || BLINK_HZ < 1 || BLINK_HALF < 1 || HOLD_CYC < 1 ||
      REPEAT_HZ < 1 || CLK_HZ / REPEAT_HZ < 1) begin : g_bad_cfg
    $error("clock_tick_ctrl: invalid timing parameters");
  end

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

  mode_t           state_reg, state_next;
  logic            btn_mode_q, btn_inc_q, armed;
  logic            rise_mode, rise_inc, rep_fire, inc_req;
  logic            clr_sec_next, inc_hr_next, inc_min_next;
  logic [PW-1:0]   presc;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;

  // armed stays low for the first edge after reset so a button already held
  // at reset release is captured into history without producing a rise.
  assign rise_mode = armed & btn_mode & ~btn_mode_q;
  assign rise_inc  = armed & btn_inc & ~btn_inc_q;
  assign inc_req   = rise_inc | rep_fire;

  // Button history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      armed      <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      armed      <= 1'b1;
    end
  end

  // Mode state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  // Next mode and next-cycle pulse requests; a mode press swallows any
  // increment arriving in the same cycle.
  always_comb begin
    state_next   = state_reg;
    clr_sec_next = 1'b0;
    inc_hr_next  = 1'b0;
    inc_min_next = 1'b0;
    if (rise_mode) begin
      case (state_reg)
        RUN:     state_next = SET_HR;
        SET_HR:  state_next = SET_MIN;
        default: begin
          state_next   = RUN;
          clr_sec_next = 1'b1;
        end
      endcase
    end else if (inc_req) begin
      inc_hr_next  = (state_reg == SET_HR);
      inc_min_next = (state_reg == SET_MIN);
    end
  end

  // Registered increment and clear pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_hr  <= 1'b0;
      inc_min <= 1'b0;
      clr_sec <= 1'b0;
    end else begin
      inc_hr  <= inc_hr_next;
      inc_min <= inc_min_next;
      clr_sec <= clr_sec_next;
    end
  end

  // Seconds prescaler: counts only while staying in RUN, parked at 0 otherwise
  // so the first tick after re-entering RUN is a full second away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else if (state_reg == RUN && !rise_mode) begin
      if (presc == PRESC_LAST) begin
        presc    <= '0;
        sec_tick <= 1'b1;
      end else begin
        presc    <= presc + PW'(1);
        sec_tick <= 1'b0;
      end
    end else begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end
  end

  // Blink timebase: runs in SET modes, restarts visible on every mode change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state_reg == RUN || rise_mode) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BW'(1);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int REPEAT_CYC = CLK_HZ / REPEAT_HZ;
  localparam int HW = $clog2(HOLD_CYC) + 1;
  localparam int RW = $clog2(REPEAT_CYC - 1) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);

  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          holding, hold_done;

  // hold_cnt==0 while held means the press was swallowed by a mode change,
  // so such a press never starts repeating.
  assign holding   = btn_inc && (state_reg != RUN) && !rise_mode;
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign rep_fire  = holding && !rise_inc && (hold_cnt != '0) &&
                     ((hold_cnt == HOLD_LAST - HW'(1)) ||
                      (hold_done && rep_cnt == REP_LAST));

  // Hold and repeat counters, cleared on release or mode change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (!holding) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (rise_inc) begin
      hold_cnt <= HW'(1);
      rep_cnt  <= '0;
    end else if (hold_cnt == '0) begin
      hold_cnt <= '0;
    end else if (!hold_done) begin
      hold_cnt <= hold_cnt + HW'(1);
    end else if (rep_cnt == REP_LAST) begin
      rep_cnt  <= '0;
    end else begin
      rep_cnt  <= rep_cnt + RW'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign mode      = state_reg;
  assign blank_hr  = (state_reg == SET_HR) & blink_phase;
  assign blank_min = (state_reg == SET_MIN) & blink_phase;

endmodule

// File: doc/clock_tick_ctrl.md
Name: clock_tick_ctrl

Overview:
Timing and mode controller for the digital clock. It replaces free-running square-wave dividers with single-cycle enable pulses. It sequences the clock through RUN / SET_HR / SET_MIN modes from two push-buttons. It produces the 1 Hz seconds tick, increment pulses for the hour and minute counters, and blink-blanking strobes for the display driver. It sits between the debounced button block and the time-counter/display datapath.

Parameters:
CLK_HZ, 50000000, input clock frequency; prescaler terminal count is CLK_HZ-1.
BLINK_HZ, 2, blink rate; blink phase toggles every BLINK_HALF = CLK_HZ/(2*BLINK_HZ) cycles.
HOLD_CYC, 25000000, cycles btn_inc must be held before auto-repeat starts.
REPEAT_HZ, 8, auto-repeat rate; REPEAT_CYC = CLK_HZ/REPEAT_HZ.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
btn_mode  in  1  debounced, clk-synchronous level, active-high; advances the mode.
btn_inc  in  1  debounced, clk-synchronous level, active-high; increments the selected field.
mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 never driven.
sec_tick  out  1  one-cycle pulse, once per CLK_HZ cycles, only in RUN.
inc_hr  out  1  one-cycle increment pulse for the hour counter.
inc_min  out  1  one-cycle increment pulse for the minute counter.
clr_sec  out  1  one-cycle pulse telling the seconds counter to clear to 00.
blank_hr  out  1  high = blank hour digits (blink off-phase in SET_HR).
blank_min  out  1  high = blank minute digits (blink off-phase in SET_MIN).

Behaviour:
- Reset (reset=0, asynchronous): mode=RUN, all pulse outputs 0, blank_* 0. Prescaler, blink, hold and repeat counters are 0. Button history registers are 0 and blink_phase=0 (visible).
- Edge detect: rise_x = btn_x & ~btn_x_q, with btn_x_q registered every cycle. A button held high through reset release does not generate a rise.
- Mode FSM, evaluated on each clk edge:
  - RUN -> SET_HR on rise_mode.
  - SET_HR -> SET_MIN on rise_mode.
  - SET_MIN -> RUN on rise_mode, and clr_sec pulses in the cycle after that edge.
  - The mode output is registered and changes at the same edge on which the rise is sampled.
- Prescaler:
  - Counts 0..CLK_HZ-1 in RUN only.
  - sec_tick is registered and high for the one cycle following the edge at which the count equals CLK_HZ-1; the count wraps to 0.
  - The prescaler holds at 0 in SET modes, so the first sec_tick after returning to RUN arrives exactly CLK_HZ cycles after the RUN entry edge.
- Increment:
  - rise_inc in SET_HR gives one inc_hr pulse in the next cycle.
  - rise_inc in SET_MIN gives one inc_min pulse in the next cycle.
  - rise_inc in RUN is ignored.
- Blink:
  - Counter runs only in SET modes; blink_phase toggles when the counter reaches BLINK_HALF-1, and the counter wraps.
  - blank_hr = (mode==SET_HR)&blink_phase; blank_min = (mode==SET_MIN)&blink_phase.
  - Any mode change clears the blink counter and blink_phase, so the newly selected field starts visible.
- Simultaneous rise_mode and rise_inc: the mode change wins and the increment is dropped. Mode change also clears the hold/repeat counters.
- inc_hr, inc_min, clr_sec and sec_tick are mutually exclusive in any cycle.
- Counter widths: each counter uses $clog2 of its terminal value + 1 bits, with no overflow past the terminal value.

Optional Feature:
AUTO_REPEAT_EN:
- When defined:
  - While btn_inc stays high in a SET mode, the hold counter counts cycles from the rise.
  - When it reaches HOLD_CYC, one extra inc pulse is emitted for the current field, then one every REPEAT_CYC cycles while btn_inc stays high.
  - Releasing btn_inc or any mode change clears both counters.
- When undefined: the hold and repeat logic is absent, and exactly one inc pulse is emitted per btn_inc rise.

Test Plan:
All scenarios use CLK_HZ=20, BLINK_HZ=2 (BLINK_HALF=5), HOLD_CYC=10, REPEAT_HZ=4 (REPEAT_CYC=5).
1. Release reset, hold idle 60 cycles -> mode=00; sec_tick pulses at cycles 20, 40, 60 after release, each 1 cycle wide; every other output stays 0.
2. Pulse btn_mode three times -> mode 00->01->10->00. clr_sec pulses exactly once, after the third press. The next sec_tick arrives 20 cycles after the RUN entry edge.
3. In SET_HR, three separate btn_inc presses -> exactly three inc_hr pulses and no inc_min. The same press in RUN -> no pulses.
4. In SET_MIN, idle 20 cycles -> blank_min is 0 for 5 cycles, then 1 for 5 cycles, repeating; blank_hr stays 0. A mode press mid-phase -> blank_* drop to 0 at once.
5. Raise btn_mode and btn_inc in the same cycle while in SET_HR -> mode=10; no inc_hr and no inc_min.
6. With AUTO_REPEAT_EN, hold btn_inc 22 cycles in SET_HR -> inc_hr pulses 1 cycle after the rise, then at +10, +15 and +20 cycles. Without the macro -> only the first pulse. Assert reset mid-hold -> all outputs 0 immediately.
